// File: rtl/deserialize.sv
// deserialize: UART RX of ASCII hex characters, assembled MS-nibble first into DATA_WIDTH-bit words.
module deserialize #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_WIDTH   = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  RxD,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid,
  output logic                  char_err,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int NW = DATA_WIDTH / 4;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t                r_state, w_state_nx;
  logic                  r_meta, r_rx;
  logic [TW-1:0]         r_timer, w_timer_nx;
  logic [2:0]            r_bit, w_bit_nx;
  logic [7:0]            r_sr, w_sr_nx;
  logic                  w_stb, w_ferr, r_stb, r_done;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [CW-1:0]         r_cnt;
  logic                  w_dig, w_alpha, w_delim, w_last, w_mid, w_half;
  logic [3:0]            w_nib;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta    <= 1'b1;
      r_rx      <= 1'b1;
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit     <= '0;
      r_sr      <= '0;
      r_stb     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_meta    <= RxD;
      r_rx      <= r_meta;
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_bit     <= w_bit_nx;
      r_sr      <= w_sr_nx;
      r_stb     <= w_stb;
      frame_err <= w_ferr;
    end
  end
  assign w_half = r_timer == TW'(CLKS_PER_BIT / 2);
  assign w_mid  = r_timer == TW'(CLKS_PER_BIT - 1);
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer + TW'(1);
    w_bit_nx   = r_bit;
    w_sr_nx    = r_sr;
    w_stb      = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_nx = '0;
        w_state_nx = r_rx ? IDLE : START;
      end
      START: if (w_half) begin
        w_timer_nx = '0;
        w_bit_nx   = '0;
        w_state_nx = r_rx ? IDLE : DATA;
      end
      DATA: if (w_mid) begin
        w_timer_nx = '0;
        w_sr_nx    = {r_rx, r_sr[7:1]};
        w_bit_nx   = r_bit + 3'd1;
        w_state_nx = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_mid) begin
        w_timer_nx = '0;
        w_stb      = r_rx;
        w_ferr     = !r_rx;
        w_state_nx = r_rx ? IDLE : WAIT_IDLE;
      end
      default: begin
        w_timer_nx = '0;
        w_state_nx = r_rx ? IDLE : WAIT_IDLE;
      end
    endcase
  end
  // r_sr holds the accepted byte during the strobe cycle: IDLE/START never touch it.
  assign w_dig   = r_sr >= 8'h30 && r_sr <= 8'h39;
  assign w_alpha = (r_sr >= 8'h41 && r_sr <= 8'h46) || (r_sr >= 8'h61 && r_sr <= 8'h66);
  assign w_delim = r_sr == 8'h0D || r_sr == 8'h0A || r_sr == 8'h20;
  assign w_nib   = w_dig ? r_sr[3:0] : r_sr[3:0] + 4'd9;
  assign w_last  = r_cnt == CW'(NW - 1);
  assign busy    = r_cnt != '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      word       <= '0;
      word_valid <= 1'b0;
      char_err   <= 1'b0;
      r_done     <= 1'b0;
      r_asm      <= '0;
      r_cnt      <= '0;
    end else begin
      word_valid <= r_done;
      r_done     <= 1'b0;
      char_err   <= 1'b0;
      if (r_done) word <= r_asm;
      if (r_stb) begin
        if (w_dig || w_alpha) begin
          r_asm  <= {r_asm[DATA_WIDTH-5:0], w_nib};
          r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
          r_done <= w_last;
        end else begin
          r_cnt    <= '0;
          char_err <= !w_delim;
        end
      end
    end
  end
endmodule

// File: tb/tb_deserialize.sv
// tb_deserialize: directed UART hex-character stimulus with a queue scoreboard of expected words.
module tb_deserialize;
  localparam int CPB = 8;
  localparam int DW  = 256;
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          RxD = 1'b1;
  logic [DW-1:0] word;
  logic          word_valid, char_err, frame_err, busy;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_acc = '0;
  logic [DW-1:0] m_last = '0;
  int            m_cnt = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            c_cerr = 0;
  int            c_ferr = 0;
  int            e_cerr = 0;
  int            e_ferr = 0;
  deserialize #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .RxD(RxD), .word(word), .word_valid(word_valid),
    .char_err(char_err), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rstn && char_err) c_cerr++;
    if (rstn && frame_err) c_ferr++;
    if (rstn && word_valid) begin
      if (q.size() == 0) chk("unexpected_word_valid", word, ~word);
      else chk("word", word, q.pop_front());
    end
  end
  task automatic model(input logic [7:0] c);
    logic [3:0] n;
    if ((c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f")) begin
      n = c <= "9" ? 4'(c - "0") : c <= "F" ? 4'(c - "A" + 10) : 4'(c - "a" + 10);
      m_acc = {m_acc[DW-5:0], n};
      m_cnt++;
      if (m_cnt == DW / 4) begin
        q.push_back(m_acc);
        m_last = m_acc;
        m_cnt = 0;
      end
    end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) m_cnt = 0;
    else begin
      m_cnt = 0;
      e_cerr++;
    end
  endtask
  task automatic frame(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = stop;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] c);
    model(c);
    frame(c, 1'b1);
  endtask
  task automatic send_str(input string s, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic settle(input string tag);
    repeat (20) @(negedge clk);
    chk({tag, "_pending"}, DW'(q.size()), '0);
    chk({tag, "_char_err"}, DW'(c_cerr), DW'(e_cerr));
    chk({tag, "_frame_err"}, DW'(c_ferr), DW'(e_ferr));
  endtask
  initial begin
    string hx;
    hx = "0123456789ABCDEF";
    repeat (3) @(negedge clk);
    chk("rst_word", word, '0);
    chk("rst_valid", DW'(word_valid), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_errs", DW'({char_err, frame_err}), '0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    send_str(hx, 4);
    settle("t1");
    chk("t1_word", word, {4{64'h0123456789ABCDEF}});
    chk("t1_busy", DW'(busy), '0);
    send_str("f", 64);
    send_str("0", 64);
    settle("t2");
    chk("t2_word", word, '0);
    send_str("0123456789", 1);
    chk("t3_busy_mid", DW'(busy), DW'(1));
    send(8'h0A);
    chk("t3_busy_lf", DW'(busy), '0);
    send_str("5", 64);
    settle("t3");
    chk("t3_word", word, {64{4'h5}});
    send_str("12G", 1);
    chk("t4_busy_after_G", DW'(busy), '0);
    send_str("A", 64);
    settle("t4");
    chk("t4_word", word, {64{4'hA}});
    e_ferr++;
    frame("7", 1'b0);
    RxD = 1'b0;
    repeat (2) @(negedge clk);
    RxD = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    settle("t5");
    chk("t5_word", word, m_last);
    chk("t5_busy", DW'(busy), '0);
    send_str(hx, 1);
    send_str("0123456789ABC", 1);
    chk("t6_busy_pre", DW'(busy), DW'(1));
    RxD = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rstn = 1'b0;
    RxD = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    m_cnt = 0;
    m_last = '0;
    chk("t6_rst_word", word, '0);
    chk("t6_rst_outs", DW'({word_valid, char_err, frame_err, busy}), '0);
    repeat (4) @(negedge clk);
    send_str("89abcdef01234567", 4);
    settle("t6");
    chk("t6_word", word, {4{64'h89ABCDEF01234567}});
    chk("t6_busy", DW'(busy), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/deserialize.md
Name: deserialize

Overview:
- Receive-side counterpart of the hex-dump UART transmitter.
- Takes a serial UART line carrying ASCII hex characters and decodes each character to a nibble.
- Assembles DATA_WIDTH/4 nibbles, most-significant first, into one word and presents it with a single-cycle valid strobe.
- Sits on the host-to-fabric path so test images and coefficients can be loaded over the same UART used for readback.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); minimum 4.
- DATA_WIDTH, 256, width of the assembled word; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- RxD  input  1  asynchronous UART serial input; idle high; 8N1, LSB first.
- word  output  DATA_WIDTH  last completed word; held until the next completion.
- word_valid  output  1  one-cycle pulse when word is updated.
- char_err  output  1  one-cycle pulse on a received non-hex, non-delimiter byte.
- frame_err  output  1  one-cycle pulse on a stop-bit error.
- busy  output  1  high while a word is partially assembled (nibble count != 0).

Behaviour:
- Reset (rstn low at a clk edge) clears word=0, word_valid=0, char_err=0, frame_err=0, busy=0, nibble count=0. The RX FSM goes to IDLE and the synchroniser flops are set to 1.
- RxD passes through a 2-flop synchroniser before any use. All timing below is measured on the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a synchronised low, go to START and clear the bit timer.
- START: at timer = CLKS_PER_BIT/2 (integer divide), resample.
  - Still low: go to DATA and clear the timer.
  - High: false start, return to IDLE with no pulse.
- DATA: sample each bit at timer = CLKS_PER_BIT-1 (mid-bit), shifting LSB first. After 8 bits go to STOP.
- STOP: sample at mid-bit.
  - High: byte is accepted (internal byte strobe, 1 cycle); go to IDLE.
  - Low: pulse frame_err, discard the byte, and go to WAIT_IDLE.
- WAIT_IDLE: stay until the synchronised RxD is high, then go to IDLE.
- Byte decode on each accepted byte:
  - '0'-'9' (0x30-0x39) decode to 0-9.
  - 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) decode to 10-15.
  - CR (0x0D), LF (0x0A) and space (0x20) are delimiters: the nibble count is cleared, the partial word is discarded, and no error is raised.
  - Any other byte: pulse char_err and clear the nibble count.
- Assembly:
  - A shift register shifts left by 4 with the new nibble in bits [3:0].
  - The first character received therefore ends in word[DATA_WIDTH-1 -: 4].
  - The count runs 0..DATA_WIDTH/4-1.
- Completion: on the nibble that makes count = DATA_WIDTH/4, in the next clk cycle:
  - word is loaded from the shift register and word_valid pulses.
  - The count wraps to 0, so back-to-back words need no delimiter.
- Latency: word_valid is asserted 2 clk cycles after the internal byte strobe of the last hex character.
- Errors and output register: char_err and frame_err never modify word. word changes only on completion.
- Error pulse timing: frame_err and char_err are each exactly 1 cycle wide. They can never coincide, because at most one byte is processed per frame.
- Reset mid-frame or mid-word: everything is abandoned. The next start bit after rstn deasserts is treated as a fresh first character.
- No backpressure: the consumer must take word within DATA_WIDTH/4 character times; word stays stable for at least that long.

Test Plan:
- Bench uses CLKS_PER_BIT=8, DATA_WIDTH=256.
- Send "0123456789ABCDEF" x4 (64 chars) -> exactly one word_valid pulse; word = 256'h0123456789ABCDEF repeated 4 times; busy low afterwards.
- Send 64 lowercase 'f' followed immediately by 64 '0' -> two word_valid pulses: word = all-ones, then 0. No char_err.
- Send 10 hex chars, then LF, then 64 x '5' -> one word_valid; word = 256'h5555...5. The partial word is discarded silently.
- Send "12G" then 64 x 'A' -> a char_err pulse on 'G'; the following word = all 0xA nibbles. No word_valid before that.
- Drive a byte with a low stop bit, then a 2-cycle low glitch on idle RxD -> one frame_err pulse; the glitch produces no byte (false start). Previous word unchanged.
- Assert rstn low for 1 cycle mid-way through character 30 -> all outputs 0. The next 64 chars yield exactly one correct word.
